// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding encodings,
// FSM state codes, default latencies and the register-match helper.
package pipe_pkg;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 33;
  localparam int DEF_CNT_W   = 6;
  localparam int DEF_STAT_W  = 16;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // $0 is hardwired to zero, so it can never be a real producer.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Forwarding select for one EXE operand; the younger EXE result wins over MEM,
// and a load in EXE cannot forward because its data is not ready yet.
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] src_addr,
  input  logic       src_used,
  input  logic       exe_rf_we,
  input  logic       exe_is_load,
  input  logic [4:0] exe_rf_waddr,
  input  logic       mem_rf_we,
  input  logic [4:0] mem_rf_waddr,
  output logic [1:0] fwd_sel
);

  always_comb begin
    // NOTE: default assignment first so every path drives fwd_sel; no latch.
    fwd_sel = FWD_RF;
    if (src_used && exe_rf_we && !exe_is_load && reg_match(src_addr, exe_rf_waddr)) begin
      fwd_sel = FWD_EXE;
    end else if (src_used && mem_rf_we && reg_match(src_addr, mem_rf_waddr)) begin
      fwd_sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller beside ID: load-use stall, branch flush, MDU hold
// sequencing, EXE operand forwarding and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int STAT_W  = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_mdu,
  input  logic              id_mdu_div,
  input  logic              id_branch_taken,
  input  logic              exe_rf_we,
  input  logic [4:0]        exe_rf_waddr,
  input  logic              exe_is_load,
  input  logic              mem_rf_we,
  input  logic [4:0]        mem_rf_waddr,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idexe_we,
  output logic              idexe_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mdu_start,
  output logic              mdu_busy,
  output logic [STAT_W-1:0] stall_cycles
);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAT_W-1:0] stall_q, stall_d;
  logic [1:0]        fwd_a, fwd_b;
  logic              load_use;

  pipe_fwd_unit u_fwd_a (
    .src_addr     (id_rs_addr),
    .src_used     (id_rs_used),
    .exe_rf_we    (exe_rf_we),
    .exe_is_load  (exe_is_load),
    .exe_rf_waddr (exe_rf_waddr),
    .mem_rf_we    (mem_rf_we),
    .mem_rf_waddr (mem_rf_waddr),
    .fwd_sel      (fwd_a)
  );

  pipe_fwd_unit u_fwd_b (
    .src_addr     (id_rt_addr),
    .src_used     (id_rt_used),
    .exe_rf_we    (exe_rf_we),
    .exe_is_load  (exe_is_load),
    .exe_rf_waddr (exe_rf_waddr),
    .mem_rf_we    (mem_rf_we),
    .mem_rf_waddr (mem_rf_waddr),
    .fwd_sel      (fwd_b)
  );

  assign load_use = exe_is_load && exe_rf_we &&
                    ((id_rs_used && reg_match(id_rs_addr, exe_rf_waddr)) ||
                     (id_rt_used && reg_match(id_rt_addr, exe_rf_waddr)));

  assign fwd_a_sel = reset ? FWD_RF : fwd_a;
  assign fwd_b_sel = reset ? FWD_RF : fwd_b;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idexe_we     = 1'b1;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b0;
    mdu_start    = 1'b0;
    if (reset) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idexe_we     = 1'b0;
      idexe_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_use) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idexe_bubble = 1'b1;
          end else if (id_is_mdu) begin
            mdu_start = 1'b1;
            cnt_d     = id_mdu_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            state_d   = ST_BUSY;
          end else if (id_branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
        default: begin
          // Front end frozen; bubbles keep EXE clean while the MDU works.
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idexe_bubble = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign stall_d = (!pc_we && (stall_q != {STAT_W{1'b1}})) ? stall_q + 1'b1 : stall_q;

  // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign mdu_busy     = (state_q == ST_BUSY);
  assign stall_cycles = stall_q;

endmodule
